// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Purpose  : MEM/WB pipeline register and writeback result select for a
//            5-stage RV32I pipeline. Captures memory-stage results, performs
//            load byte/half extraction with sign or zero extension, and
//            drives the register-file write port and the WB forwarding value.
//            Latency from M to W is one clock.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst          in   synchronous active-high reset
//   StallW       in   hold W register contents
//   FlushW       in   load a bubble into W (overrides StallW)
//   ValidM       in   M slot holds a real instruction
//   RegWriteM    in   instruction writes rd
//   ResultSrcM   in   [1:0] 00 ALU, 01 load, 10 PC+4, 11 reserved (zero)
//   Funct3M      in   [2:0] load type
//   RdM          in   destination register
//   ALUResultM   in   ALU result / load byte address
//   ReadDataM    in   raw aligned data-memory word
//   PCPlus4M     in   link value
//   RdW          out  register-file A3
//   ResultW      out  register-file WD3 and forwarding value
//   RegWriteW    out  register-file WE3, qualified by valid and rd != x0
//   ValidW       out  W slot holds a real instruction
//   RetireCnt    out  [31:0] retired-instruction counter (optional)
// ----------------------------------------------------------------------------
// Build option
//   WB_RETIRE_CNT_EN : when defined, adds the RetireCnt output and counter.
// ============================================================================
module writeback_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     StallW,
  input  logic                     FlushW,
  input  logic                     ValidM,
  input  logic                     RegWriteM,
  input  logic [1:0]               ResultSrcM,
  input  logic [2:0]               Funct3M,
  input  logic [ADDRESS_WIDTH-1:0] RdM,
  input  logic [DATA_WIDTH-1:0]    ALUResultM,
  input  logic [DATA_WIDTH-1:0]    ReadDataM,
  input  logic [DATA_WIDTH-1:0]    PCPlus4M,
`ifdef WB_RETIRE_CNT_EN
  output logic [31:0]              RetireCnt,
`endif
  output logic [ADDRESS_WIDTH-1:0] RdW,
  output logic [DATA_WIDTH-1:0]    ResultW,
  output logic                     RegWriteW,
  output logic                     ValidW
);

  // Result source encodings
  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // --------------------------------------------------------------------------
  // W pipeline register
  // --------------------------------------------------------------------------
  logic                     valid_q,      valid_d;
  logic                     regwrite_q,   regwrite_d;
  logic [1:0]               result_src_q, result_src_d;
  logic [2:0]               funct3_q,     funct3_d;
  logic [ADDRESS_WIDTH-1:0] rd_q,         rd_d;
  logic [DATA_WIDTH-1:0]    alu_result_q, alu_result_d;
  logic [DATA_WIDTH-1:0]    read_data_q,  read_data_d;
  logic [DATA_WIDTH-1:0]    pc_plus4_q,   pc_plus4_d;

  // Next-state select: flush beats stall, stall holds, otherwise capture.
  always_comb begin
    valid_d      = valid_q;
    regwrite_d   = regwrite_q;
    result_src_d = result_src_q;
    funct3_d     = funct3_q;
    rd_d         = rd_q;
    alu_result_d = alu_result_q;
    read_data_d  = read_data_q;
    pc_plus4_d   = pc_plus4_q;

    if (FlushW) begin
      valid_d      = 1'b0;
      regwrite_d   = 1'b0;
      result_src_d = 2'b00;
      funct3_d     = 3'b000;
      rd_d         = '0;
      alu_result_d = '0;
      read_data_d  = '0;
      pc_plus4_d   = '0;
    end else if (!StallW) begin
      valid_d      = ValidM;
      regwrite_d   = RegWriteM;
      result_src_d = ResultSrcM;
      funct3_d     = Funct3M;
      rd_d         = RdM;
      alu_result_d = ALUResultM;
      read_data_d  = ReadDataM;
      pc_plus4_d   = PCPlus4M;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      result_src_q <= 2'b00;
      funct3_q     <= 3'b000;
      rd_q         <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      pc_plus4_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      regwrite_q   <= regwrite_d;
      result_src_q <= result_src_d;
      funct3_q     <= funct3_d;
      rd_q         <= rd_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
      pc_plus4_q   <= pc_plus4_d;
    end
  end

  // --------------------------------------------------------------------------
  // Load extraction. The memory returns the aligned word; the low address
  // bits pick the byte or half within it.
  // --------------------------------------------------------------------------
  logic [1:0]            load_off;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [DATA_WIDTH-1:0] load_value;

  assign load_off = alu_result_q[1:0];

  always_comb begin
    load_byte = read_data_q[7:0];
    case (load_off)
      2'd0:    load_byte = read_data_q[7:0];
      2'd1:    load_byte = read_data_q[15:8];
      2'd2:    load_byte = read_data_q[23:16];
      default: load_byte = read_data_q[31:24];
    endcase
    // Halfword accesses ignore off[0]; only the upper/lower half is chosen.
    load_half = load_off[1] ? read_data_q[31:16] : read_data_q[15:0];
  end

  always_comb begin
    load_value = read_data_q;
    case (funct3_q)
      F3_LB:   load_value = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
      F3_LH:   load_value = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
      F3_LW:   load_value = read_data_q;
      F3_LBU:  load_value = {{(DATA_WIDTH-8){1'b0}}, load_byte};
      F3_LHU:  load_value = {{(DATA_WIDTH-16){1'b0}}, load_half};
      // Undefined load types pass the raw word through.
      default: load_value = read_data_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Result select and write enable. Both are combinational from the W
  // register so they stay stable from the capture edge through the falling
  // edge on which the register file commits.
  // --------------------------------------------------------------------------
  always_comb begin
    ResultW = '0;
    case (result_src_q)
      SRC_ALU:  ResultW = alu_result_q;
      SRC_LOAD: ResultW = load_value;
      SRC_PC4:  ResultW = pc_plus4_q;
      default:  ResultW = '0;
    endcase
  end

  // Writes to x0 are suppressed here so the register file never sees them.
  assign RegWriteW = regwrite_q & valid_q & (rd_q != '0);
  assign RdW       = rd_q;
  assign ValidW    = valid_q;

`ifdef WB_RETIRE_CNT_EN
  // --------------------------------------------------------------------------
  // Retire counter: an instruction retires when it leaves W, i.e. W is valid
  // and not stalled. A flush on the same edge still lets the departing
  // instruction count. Wraps naturally at 2^32.
  // --------------------------------------------------------------------------
  logic [31:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (valid_q && !StallW) begin
      retire_cnt_d = retire_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_q <= 32'd0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign RetireCnt = retire_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Purpose  : Self-checking bench for writeback_stage. Directed cases for ALU,
//            load, link, stall/flush and reset, followed by randomized
//            traffic compared against a behavioural reference model.
// Revision : 1.0 - initial release
// Build option: WB_RETIRE_CNT_EN enables the retire-counter checks.
// ============================================================================
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallW, FlushW, ValidM, RegWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, ReadDataM, PCPlus4M;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        RegWriteW, ValidW;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] RetireCnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  writeback_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .StallW     (StallW),
    .FlushW     (FlushW),
    .ValidM     (ValidM),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .Funct3M    (Funct3M),
    .RdM        (RdM),
    .ALUResultM (ALUResultM),
    .ReadDataM  (ReadDataM),
    .PCPlus4M   (PCPlus4M),
`ifdef WB_RETIRE_CNT_EN
    .RetireCnt  (RetireCnt),
`endif
    .RdW        (RdW),
    .ResultW    (ResultW),
    .RegWriteW  (RegWriteW),
    .ValidW     (ValidW)
  );

  // Reference model: the instruction currently sitting in W.
  logic        m_valid, m_rw;
  logic [1:0]  m_src;
  logic [2:0]  m_f3;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_rdata, m_pc;
  logic [31:0] m_cnt;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Architectural meaning of a load: shift the wanted byte/half down,
  // then extend by arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                           input logic [31:0] addr,
                                           input logic [31:0] word);
    int unsigned b, h;
    b = (word >> (8 * (addr % 4))) & 32'hFF;
    h = (word >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b - 256 : b;
      3'b001:  return (h >= 32768) ? h - 65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] ref_result();
    case (m_src)
      2'b00:   return m_alu;
      2'b01:   return ref_load(m_f3, m_alu, m_rdata);
      2'b10:   return m_pc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_m(input logic v, input logic rw, input logic [1:0] src,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] pc);
    ValidM = v; RegWriteM = rw; ResultSrcM = src; Funct3M = f3; RdM = rd;
    ALUResultM = alu; ReadDataM = rdata; PCPlus4M = pc;
  endtask

  task automatic set_rand_m();
    set_m($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
          3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom,
          $urandom, $urandom);
  endtask

  // One clock: advance the model with the values present at the edge, then
  // compare all outputs shortly after the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) m_cnt = 32'd0;
    else if (m_valid && !StallW) m_cnt = m_cnt + 32'd1;
    if (rst || FlushW) begin
      m_valid = 0; m_rw = 0; m_src = 0; m_f3 = 0; m_rd = 0;
      m_alu = 0; m_rdata = 0; m_pc = 0;
    end else if (!StallW) begin
      m_valid = ValidM; m_rw = RegWriteM; m_src = ResultSrcM; m_f3 = Funct3M;
      m_rd = RdM; m_alu = ALUResultM; m_rdata = ReadDataM; m_pc = PCPlus4M;
    end
    #1;
    check_val("RdW", 32'(RdW), 32'(m_rd));
    check_val("ValidW", 32'(ValidW), 32'(m_valid));
    check_val("RegWriteW", 32'(RegWriteW), 32'(m_rw && m_valid && m_rd != 0));
    check_val("ResultW", ResultW, ref_result());
`ifdef WB_RETIRE_CNT_EN
    check_val("RetireCnt", RetireCnt, m_cnt);
`endif
  endtask

  initial begin
    m_valid = 0; m_rw = 0; m_src = 0; m_f3 = 0; m_rd = 0;
    m_alu = 0; m_rdata = 0; m_pc = 0; m_cnt = 0;
    rst = 1; StallW = 0; FlushW = 0;
    set_rand_m();
    tick();
    tick();
    check_val("reset_ResultW", ResultW, 32'd0);
    check_val("reset_ValidW", 32'(ValidW), 32'd0);
    rst = 0;

    // ALU writeback
    set_m(1, 1, 2'b00, 3'b000, 5'd5, 32'h1234, 32'hDEADBEEF, 32'h40);
    tick();
    check_val("alu_ResultW", ResultW, 32'h1234);
    check_val("alu_RdW", 32'(RdW), 32'd5);
    check_val("alu_RegWriteW", 32'(RegWriteW), 32'd1);

    // Loads from 0x80F17F22
    set_m(1, 1, 2'b01, 3'b000, 5'd6, 32'h1000, 32'h80F17F22, 32'h0); tick();
    check_val("LB_off0", ResultW, 32'h00000022);
    set_m(1, 1, 2'b01, 3'b000, 5'd6, 32'h1003, 32'h80F17F22, 32'h0); tick();
    check_val("LB_off3", ResultW, 32'hFFFFFF80);
    set_m(1, 1, 2'b01, 3'b100, 5'd6, 32'h1003, 32'h80F17F22, 32'h0); tick();
    check_val("LBU_off3", ResultW, 32'h00000080);
    set_m(1, 1, 2'b01, 3'b001, 5'd6, 32'h1002, 32'h80F17F22, 32'h0); tick();
    check_val("LH_off2", ResultW, 32'hFFFF80F1);
    set_m(1, 1, 2'b01, 3'b101, 5'd6, 32'h1002, 32'h80F17F22, 32'h0); tick();
    check_val("LHU_off2", ResultW, 32'h000080F1);
    set_m(1, 1, 2'b01, 3'b010, 5'd6, 32'h1001, 32'h80F17F22, 32'h0); tick();
    check_val("LW", ResultW, 32'h80F17F22);

    // JAL link, then the same to x0
    set_m(1, 1, 2'b10, 3'b000, 5'd1, 32'h55, 32'h0, 32'h104); tick();
    check_val("jal_ResultW", ResultW, 32'h104);
    check_val("jal_RegWriteW", 32'(RegWriteW), 32'd1);
    set_m(1, 1, 2'b10, 3'b000, 5'd0, 32'h55, 32'h0, 32'h104); tick();
    check_val("jal_x0_RegWriteW", 32'(RegWriteW), 32'd0);

    // Stall holds instr A for three cycles, then flush+stall makes a bubble
    set_m(1, 1, 2'b00, 3'b000, 5'd9, 32'hA5A5_0001, 32'h0, 32'h0); tick();
    StallW = 1;
    for (int i = 0; i < 3; i++) begin
      set_rand_m();
      tick();
      check_val("stall_RdW", 32'(RdW), 32'd9);
      check_val("stall_ResultW", ResultW, 32'hA5A5_0001);
    end
    FlushW = 1;
    tick();
    check_val("flush_ValidW", 32'(ValidW), 32'd0);
    check_val("flush_RegWriteW", 32'(RegWriteW), 32'd0);
    StallW = 0; FlushW = 0;

    // Reset mid-stream with a valid instruction in W
    set_m(1, 1, 2'b00, 3'b000, 5'd7, 32'h77, 32'h0, 32'h0); tick();
    rst = 1; tick();
    check_val("rst_mid_ResultW", ResultW, 32'd0);
    check_val("rst_mid_RdW", 32'(RdW), 32'd0);
    rst = 0;
    set_m(0, 1, 2'b00, 3'b000, 5'd7, 32'h77, 32'h0, 32'h0); tick();
    check_val("rst_resume_RegWriteW", 32'(RegWriteW), 32'd0);

`ifdef WB_RETIRE_CNT_EN
    // Four valid, one bubble, two stalls -> four retirements
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 4; i++) begin
      set_m(1, 1, 2'b00, 3'b000, 5'(i + 1), 32'(i), 32'h0, 32'h0); tick();
    end
    set_m(0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0); tick();
    StallW = 1; tick(); tick(); StallW = 0;
    check_val("retire_cnt_4", RetireCnt, 32'd4);

    // Wrap: preload all-ones with a valid instruction in W, retire it
    set_m(1, 1, 2'b00, 3'b000, 5'd3, 32'h3, 32'h0, 32'h0); tick();
    @(negedge clk);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    set_m(0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0); tick();
    check_val("retire_cnt_wrap", RetireCnt, 32'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_rand_m();
      StallW = ($urandom_range(0, 3) == 0);
      FlushW = ($urandom_range(0, 7) == 0);
      rst    = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 0; StallW = 0; FlushW = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register plus writeback result select for the 5-stage RV32I pipeline.
- Captures memory-stage results, performs load byte/half extraction and extension, and selects the final result.
- Drives the register file write port (A3/WD3/WE3) and the WB-stage forwarding value to the hazard/forwarding unit.
- One cycle of latency from M to W.

Parameters:
- DATA_WIDTH, 32, datapath width
- ADDRESS_WIDTH, 5, register index width

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- StallW  input  1  hold W register contents
- FlushW  input  1  load a bubble into W
- ValidM  input  1  M-stage slot holds a real instruction
- RegWriteM  input  1  instruction writes rd
- ResultSrcM  input  2  00 ALU, 01 load, 10 PC+4, 11 reserved
- Funct3M  input  3  load type
- RdM  input  ADDRESS_WIDTH  destination register
- ALUResultM  input  DATA_WIDTH  ALU result / load byte address
- ReadDataM  input  DATA_WIDTH  raw aligned data-memory word
- PCPlus4M  input  DATA_WIDTH  link value
- RdW  output  ADDRESS_WIDTH  register-file A3
- ResultW  output  DATA_WIDTH  register-file WD3 and forwarding value
- RegWriteW  output  1  register-file WE3 (qualified)
- ValidW  output  1  W slot holds a real instruction

Behaviour:
- Rising-edge update priority:
  - rst: clear all W state, including the internal ALUResultW, ReadDataW, PCPlus4W, Funct3W and ResultSrcW; ValidW=0, RegWriteW=0, RdW=0, ResultW=0.
  - else FlushW: load a bubble (valid=0, regwrite=0, rd=0, data fields=0). FlushW overrides StallW.
  - else StallW: hold all W state unchanged.
  - else: capture every M input into the W registers.
- RegWriteW = registered RegWrite AND ValidW AND (RdW != 0). It is combinational from the W registers, and writes to x0 are never asserted.
- ResultW is combinational from the W registers:
  - 00: ALUResultW.
  - 01: LoadValue.
  - 10: PCPlus4W.
  - 11: 0.
- LoadValue, with off = ALUResultW[1:0]:
  - 000 LB: byte at bits [8*off+7 : 8*off], sign-extended.
  - 001 LH: half selected by off[1] (0 = bits [15:0], 1 = bits [31:16]), sign-extended; off[0] is ignored.
  - 010 LW: full word; off is ignored.
  - 100 LBU: as LB, zero-extended.
  - 101 LHU: as LH, zero-extended.
  - 011, 110, 111: full word, unmodified.
- Bubble or reset: ResultW still evaluates from the cleared fields (0); RegWriteW=0.
- The register file commits on the falling clock edge, so ResultW and RdW must be stable from the W-capture rising edge through the following falling edge. No other timing requirement.
- Back-to-back instructions: each is presented for exactly one cycle when StallW=0.
- Reset mid-stall: reset wins and clears state.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined:
  - Adds output RetireCnt (32 bits), reset to 0.
  - Increments on a rising edge where rst=0, ValidW=1 and StallW=0, i.e. the instruction leaves W. A flush on the same edge still counts the departing valid instruction.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- ALU writeback: ValidM=1, RegWriteM=1, RdM=5, ResultSrcM=00, ALUResultM=0x1234 -> next cycle RdW=5, ResultW=0x1234, RegWriteW=1.
- Loads: ReadDataM=0x80F17F22 with ALUResultM low bits and Funct3M set as below; expected ResultW:
  - LB off=0 -> 0x00000022
  - LB off=3 -> 0xFFFFFF80
  - LBU off=3 -> 0x00000080
  - LH off=2 -> 0xFFFF80F1
  - LHU off=2 -> 0x000080F1
  - LW -> 0x80F17F22
- JAL link: ResultSrcM=10, PCPlus4M=0x104, RdM=1 -> ResultW=0x104, RdW=1, RegWriteW=1. Same with RdM=0 -> RegWriteW=0.
- Stall/flush: capture instr A, then StallW=1 for 3 cycles with new M inputs -> W holds A. Then FlushW=1 and StallW=1 together -> ValidW=0, RegWriteW=0.
- Reset: drive rst=1 for one cycle mid-stream with a valid instruction in W -> after the edge all outputs are 0 (RetireCnt=0 if enabled). Resume with no spurious write.
- WB_RETIRE_CNT_EN: 4 valid instructions, 1 bubble, 2 stall cycles -> RetireCnt=4. Preload the counter to 0xFFFFFFFF via a long run (force in bench) and retire one more -> 0.
